// File: rtl/local_sram_arbiter.sv
// local_sram_arbiter
// Shares two local SRAM macros between the core and wishbone local-memory
// requesters. Port 0 is read/write, port 1 is read-only; each port spans two
// 32-bit banks selected by one address bit. Each requester has a two-state
// FSM (IDLE, ACK): a request granted in cycle T completes in T+1.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   core_* / wb_*                requester interfaces (enable, writeEnable,
//                                address, byteSelect, dataWrite, dataRead, busy)
//   clk0/csb0/web0/wmask0/addr0/din0/dout0   SRAM read/write port
//   clk1/csb1/addr1/dout1                    SRAM read-only port
module local_sram_arbiter #(
  parameter int SRAM_ADDRESS_SIZE = 9
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         core_enable,
  input  logic                         core_writeEnable,
  input  logic [23:0]                  core_address,
  input  logic [3:0]                   core_byteSelect,
  input  logic [31:0]                  core_dataWrite,
  output logic [31:0]                  core_dataRead,
  output logic                         core_busy,
  input  logic                         wb_enable,
  input  logic                         wb_writeEnable,
  input  logic [23:0]                  wb_address,
  input  logic [3:0]                   wb_byteSelect,
  input  logic [31:0]                  wb_dataWrite,
  output logic [31:0]                  wb_dataRead,
  output logic                         wb_busy,
  output logic                         clk0,
  output logic [1:0]                   csb0,
  output logic                         web0,
  output logic [3:0]                   wmask0,
  output logic [SRAM_ADDRESS_SIZE-1:0] addr0,
  output logic [31:0]                  din0,
  input  logic [63:0]                  dout0,
  output logic                         clk1,
  output logic [1:0]                   csb1,
  output logic [SRAM_ADDRESS_SIZE-1:0] addr1,
  input  logic [63:0]                  dout1
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } req_state_t;

  req_state_t core_state;
  req_state_t wb_state;
  logic       rr_ptr;        // 0 = core wins next write contention, 1 = wb
  logic       core_from_p1;  // port/bank/kind captured at grant for the ACK cycle
  logic       core_bank_q;
  logic       core_is_read;
  logic       wb_from_p1;
  logic       wb_bank_q;
  logic       wb_is_read;

  logic                         core_elig;
  logic                         wb_elig;
  logic                         core_grant;
  logic                         wb_grant;
  logic                         core_on_p0;
  logic                         wb_on_p0;
  logic                         contended;
  logic [SRAM_ADDRESS_SIZE-1:0] core_row;
  logic [SRAM_ADDRESS_SIZE-1:0] wb_row;
  logic                         core_bank;
  logic                         wb_bank;
  logic                         unused_addr_bits;

  // Chip-select pattern for a one-bank access (active low).
  function automatic logic [1:0] bank_csb(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction

  // Pick the 32-bit half of a 64-bit macro output belonging to one bank.
  function automatic logic [31:0] bank_word(input logic [63:0] d, input logic bank);
    return bank ? d[63:32] : d[31:0];
  endfunction

  assign clk0 = wb_clk_i;
  assign clk1 = wb_clk_i;

  // Upper address bits alias and byte offset bits are dropped.
  assign core_row  = core_address[SRAM_ADDRESS_SIZE+1:2];
  assign wb_row    = wb_address[SRAM_ADDRESS_SIZE+1:2];
  assign core_bank = core_address[SRAM_ADDRESS_SIZE+2];
  assign wb_bank   = wb_address[SRAM_ADDRESS_SIZE+2];
  assign unused_addr_bits = ^{core_address[23:SRAM_ADDRESS_SIZE+3], core_address[1:0],
                              wb_address[23:SRAM_ADDRESS_SIZE+3], wb_address[1:0]};

  // Reset blocks all grants so the SRAM pins sit idle while it is asserted.
  assign core_elig = !wb_rst_i && core_enable && (core_state == IDLE);
  assign wb_elig   = !wb_rst_i && wb_enable && (wb_state == IDLE);

  assign core_busy = core_enable && (wb_rst_i || (core_state != ACK));
  assign wb_busy   = wb_enable && (wb_rst_i || (wb_state != ACK));

  // Grant decision and port assignment for the eligible requesters.
  always_comb begin
    core_grant = 1'b0;
    wb_grant   = 1'b0;
    core_on_p0 = 1'b0;
    wb_on_p0   = 1'b0;
    contended  = 1'b0;
    case ({core_elig, wb_elig})
      2'b10: begin
        core_grant = 1'b1;
        core_on_p0 = core_writeEnable;
      end
      2'b01: begin
        wb_grant = 1'b1;
        wb_on_p0 = wb_writeEnable;
      end
      2'b11: begin
        if (core_writeEnable && wb_writeEnable) begin
          // Only port 0 can write: round-robin picks one, the other waits.
          contended  = 1'b1;
          core_on_p0 = 1'b1;
          wb_on_p0   = 1'b1;
          core_grant = (rr_ptr == 1'b0);
          wb_grant   = (rr_ptr == 1'b1);
        end else begin
          // Writer (if any) takes port 0; with two reads core takes port 1.
          core_grant = 1'b1;
          wb_grant   = 1'b1;
          core_on_p0 = core_writeEnable;
          wb_on_p0   = !core_writeEnable;
        end
      end
      default: begin
        core_grant = 1'b0;
        wb_grant   = 1'b0;
      end
    endcase
  end

  // Drive the read/write port from whichever requester was placed on it.
  always_comb begin
    csb0   = 2'b11;
    web0   = 1'b1;
    wmask0 = 4'h0;
    addr0  = '0;
    din0   = 32'h0;
    if (core_grant && core_on_p0) begin
      csb0   = bank_csb(core_bank);
      web0   = !core_writeEnable;
      wmask0 = core_writeEnable ? core_byteSelect : 4'h0;
      addr0  = core_row;
      din0   = core_writeEnable ? core_dataWrite : 32'h0;
    end else if (wb_grant && wb_on_p0) begin
      csb0   = bank_csb(wb_bank);
      web0   = !wb_writeEnable;
      wmask0 = wb_writeEnable ? wb_byteSelect : 4'h0;
      addr0  = wb_row;
      din0   = wb_writeEnable ? wb_dataWrite : 32'h0;
    end else begin
      csb0 = 2'b11;
    end
  end

  // Drive the read-only port.
  always_comb begin
    csb1  = 2'b11;
    addr1 = '0;
    if (core_grant && !core_on_p0) begin
      csb1  = bank_csb(core_bank);
      addr1 = core_row;
    end else if (wb_grant && !wb_on_p0) begin
      csb1  = bank_csb(wb_bank);
      addr1 = wb_row;
    end else begin
      csb1 = 2'b11;
    end
  end

  // Return read data in the ACK cycle; writes complete with zero data.
  always_comb begin
    core_dataRead = 32'h0;
    wb_dataRead   = 32'h0;
    if (!wb_rst_i && (core_state == ACK) && core_is_read) begin
      core_dataRead = core_from_p1 ? bank_word(dout1, core_bank_q)
                                   : bank_word(dout0, core_bank_q);
    end else begin
      core_dataRead = 32'h0;
    end
    if (!wb_rst_i && (wb_state == ACK) && wb_is_read) begin
      wb_dataRead = wb_from_p1 ? bank_word(dout1, wb_bank_q)
                               : bank_word(dout0, wb_bank_q);
    end else begin
      wb_dataRead = 32'h0;
    end
  end

  // Requester FSMs, round-robin pointer and per-grant read routing.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_state   <= IDLE;
      wb_state     <= IDLE;
      rr_ptr       <= 1'b0;
      core_from_p1 <= 1'b0;
      core_bank_q  <= 1'b0;
      core_is_read <= 1'b0;
      wb_from_p1   <= 1'b0;
      wb_bank_q    <= 1'b0;
      wb_is_read   <= 1'b0;
    end else begin
      // A granted requester is always IDLE, so ACK falls back to IDLE.
      core_state <= core_grant ? ACK : IDLE;
      wb_state   <= wb_grant ? ACK : IDLE;
      if (contended) begin
        rr_ptr <= !rr_ptr;
      end
      if (core_grant) begin
        core_from_p1 <= !core_on_p0;
        core_bank_q  <= core_bank;
        core_is_read <= !core_writeEnable;
      end
      if (wb_grant) begin
        wb_from_p1 <= !wb_on_p0;
        wb_bank_q  <= wb_bank;
        wb_is_read <= !wb_writeEnable;
      end
    end
  end

endmodule

// File: tb/tb_local_sram_arbiter.sv
// Self-checking bench for local_sram_arbiter: table-driven single-shot
// vectors with a read-data scoreboard, plus hand sequences for write
// contention/round-robin and reset during a request.
module tb_local_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_en, c_we, w_en, w_we;
  logic [23:0] c_addr, w_addr;
  logic [3:0]  c_sel, w_sel;
  logic [31:0] c_dat, w_dat, c_rd, w_rd;
  logic        c_busy, w_busy;
  logic        clk0, clk1, web0;
  logic [1:0]  csb0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0;
  logic [63:0] dout0, dout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  local_sram_arbiter #(.SRAM_ADDRESS_SIZE(9)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .core_enable(c_en), .core_writeEnable(c_we), .core_address(c_addr),
    .core_byteSelect(c_sel), .core_dataWrite(c_dat), .core_dataRead(c_rd),
    .core_busy(c_busy),
    .wb_enable(w_en), .wb_writeEnable(w_we), .wb_address(w_addr),
    .wb_byteSelect(w_sel), .wb_dataWrite(w_dat), .wb_dataRead(w_rd),
    .wb_busy(w_busy),
    .clk0(clk0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0),
    .clk1(clk1), .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  typedef struct {
    logic cen; logic cwe; logic [23:0] caddr; logic [3:0] csel; logic [31:0] cdat;
    logic wen; logic wwe; logic [23:0] waddr; logic [3:0] wsel; logic [31:0] wdat;
    logic [63:0] d0; logic [63:0] d1;
    logic [1:0] csb0; logic web0; logic [3:0] wmask0; logic [8:0] addr0; logic [31:0] din0;
    logic [1:0] csb1; logic [8:0] addr1;
    logic [31:0] crd; logic [31:0] wrd;
  } vec_t;

  typedef struct {
    logic [31:0] crd;
    logic [31:0] wrd;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c_en = 1'b0; c_we = 1'b0; c_addr = 24'h0; c_sel = 4'h0; c_dat = 32'h0;
    w_en = 1'b0; w_we = 1'b0; w_addr = 24'h0; w_sel = 4'h0; w_dat = 32'h0;
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, " csb0"}, csb0, 2'b11);
    chk({tag, " csb1"}, csb1, 2'b11);
    chk({tag, " web0"}, web0, 1'b1);
    chk({tag, " wmask0"}, wmask0, 4'h0);
    chk({tag, " addr0"}, addr0, 9'h0);
    chk({tag, " addr1"}, addr1, 9'h0);
    chk({tag, " din0"}, din0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    idle_inputs();
    dout0 = 64'h0;
    dout1 = 64'h0;

    //            core: en we addr sel data | wb: en we addr sel data | dout0 dout1 | port0 csb web mask addr din | port1 csb addr | core rd, wb rd
    vecs[0] = '{1'b1, 1'b0, 24'h000104, 4'h0, 32'h0, 1'b0, 1'b0, 24'h0, 4'h0, 32'h0,
                64'h0, 64'hCAFE0000_DEADBEEF,
                2'b11, 1'b1, 4'h0, 9'h000, 32'h0, 2'b10, 9'h041, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 24'h000800, 4'h0, 32'h0, 1'b1, 1'b0, 24'h000800, 4'h0, 32'h0,
                64'h11112222_33334444, 64'h55556666_77778888,
                2'b01, 1'b1, 4'h0, 9'h000, 32'h0, 2'b01, 9'h000, 32'h55556666, 32'h11112222};
    vecs[2] = '{1'b1, 1'b1, 24'h000010, 4'b0011, 32'h1234ABCD, 1'b1, 1'b0, 24'h000020, 4'h0, 32'h0,
                64'h0, 64'h00000000_ABCDEF01,
                2'b10, 1'b0, 4'h3, 9'h004, 32'h1234ABCD, 2'b10, 9'h008, 32'h0, 32'hABCDEF01};
    vecs[3] = '{1'b1, 1'b0, 24'h000004, 4'h0, 32'h0, 1'b1, 1'b1, 24'h001FFC, 4'hF, 32'hA5A55A5A,
                64'h0, 64'h00000000_0BADF00D,
                2'b01, 1'b0, 4'hF, 9'h1FF, 32'hA5A55A5A, 2'b10, 9'h001, 32'h0BADF00D, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 24'h001004, 4'h0, 32'h0, 1'b0, 1'b0, 24'h0, 4'h0, 32'h0,
                64'h0, 64'h00000000_600DF00D,
                2'b11, 1'b1, 4'h0, 9'h000, 32'h0, 2'b10, 9'h001, 32'h600DF00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 24'h0, 4'h0, 32'h0, 1'b1, 1'b0, 24'h000808, 4'h0, 32'h0,
                64'h0, 64'h87654321_00000000,
                2'b11, 1'b1, 4'h0, 9'h000, 32'h0, 2'b01, 9'h002, 32'h0, 32'h87654321};
    vecs[6] = '{1'b1, 1'b1, 24'h00000C, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 24'h0, 4'h0, 32'h0,
                64'h0, 64'h0,
                2'b10, 1'b0, 4'h0, 9'h003, 32'hFFFFFFFF, 2'b11, 9'h000, 32'h0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 24'h000808, 4'h0, 32'h0, 1'b1, 1'b0, 24'h00000C, 4'h0, 32'h0,
                64'h00000001_C0FFEE00, 64'h13572468_00000002,
                2'b10, 1'b1, 4'h0, 9'h003, 32'h0, 2'b01, 9'h002, 32'h13572468, 32'hC0FFEE00};
    vecs[8] = '{1'b0, 1'b0, 24'h0, 4'h0, 32'h0, 1'b1, 1'b1, 24'h000800, 4'h8, 32'h00000077,
                64'h0, 64'h0,
                2'b01, 1'b0, 4'h8, 9'h000, 32'h00000077, 2'b11, 9'h000, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 24'h0, 4'h0, 32'h0, 1'b0, 1'b0, 24'h0, 4'h0, 32'h0,
                64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
                2'b11, 1'b1, 4'h0, 9'h000, 32'h0, 2'b11, 9'h000, 32'h0, 32'h0};

    // Reset state, including busy following enable while reset is held.
    repeat (2) @(negedge clk);
    #2;
    chk_idle_pins("rst");
    chk("rst core_busy", c_busy, 1'b0);
    chk("rst core_rd", c_rd, 32'h0);
    chk("rst wb_rd", w_rd, 32'h0);
    @(negedge clk);
    c_en = 1'b1;
    w_en = 1'b1;
    #2;
    chk("rst core_busy en", c_busy, 1'b1);
    chk("rst wb_busy en", w_busy, 1'b1);
    chk("rst csb1 en", csb1, 2'b11);
    do_reset();

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_en = vecs[i].cen; c_we = vecs[i].cwe; c_addr = vecs[i].caddr;
      c_sel = vecs[i].csel; c_dat = vecs[i].cdat;
      w_en = vecs[i].wen; w_we = vecs[i].wwe; w_addr = vecs[i].waddr;
      w_sel = vecs[i].wsel; w_dat = vecs[i].wdat;
      dout0 = vecs[i].d0; dout1 = vecs[i].d1;
      sb.push_back('{crd: vecs[i].crd, wrd: vecs[i].wrd});
      #2;
      chk($sformatf("v%0d csb0", i), csb0, vecs[i].csb0);
      chk($sformatf("v%0d web0", i), web0, vecs[i].web0);
      chk($sformatf("v%0d wmask0", i), wmask0, vecs[i].wmask0);
      chk($sformatf("v%0d addr0", i), addr0, vecs[i].addr0);
      chk($sformatf("v%0d din0", i), din0, vecs[i].din0);
      chk($sformatf("v%0d csb1", i), csb1, vecs[i].csb1);
      chk($sformatf("v%0d addr1", i), addr1, vecs[i].addr1);
      chk($sformatf("v%0d core_busy T", i), c_busy, vecs[i].cen);
      chk($sformatf("v%0d wb_busy T", i), w_busy, vecs[i].wen);
      @(negedge clk);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d core_busy T+1", i), c_busy, 1'b0);
      chk($sformatf("v%0d wb_busy T+1", i), w_busy, 1'b0);
      chk($sformatf("v%0d core_rd", i), c_rd, e.crd);
      chk($sformatf("v%0d wb_rd", i), w_rd, e.wrd);
      @(negedge clk);
      idle_inputs();
      #2;
      chk($sformatf("v%0d core_rd after", i), c_rd, 32'h0);
    end

    // Continuous write contention from a fresh reset (pointer at core).
    do_reset();
    @(negedge clk);
    c_en = 1'b1; c_we = 1'b1; c_addr = 24'h000010; c_sel = 4'hF; c_dat = 32'hC0C0C0C0;
    w_en = 1'b1; w_we = 1'b1; w_addr = 24'h000020; w_sel = 4'hF; w_dat = 32'hB0B0B0B0;
    for (int k = 0; k < 9; k++) begin
      #2;
      chk($sformatf("cont%0d addr0", k), addr0, (k % 2 == 0) ? 9'h004 : 9'h008);
      chk($sformatf("cont%0d din0", k), din0, (k % 2 == 0) ? 32'hC0C0C0C0 : 32'hB0B0B0B0);
      chk($sformatf("cont%0d web0", k), web0, 1'b0);
      chk($sformatf("cont%0d core_busy", k), c_busy, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("cont%0d wb_busy", k), w_busy, (k == 0 || k % 2 == 1) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    // One contended grant so far: wb now wins, then the pointer returns to core.
    c_en = 1'b1; c_we = 1'b1; c_addr = 24'h000010; c_sel = 4'hF;
    w_en = 1'b1; w_we = 1'b1; w_addr = 24'h000020; w_sel = 4'hF;
    #2;
    chk("rr2 addr0 wb wins", addr0, 9'h008);
    chk("rr2 core_busy", c_busy, 1'b1);
    @(negedge clk);
    #2;
    chk("rr2 addr0 core next", addr0, 9'h004);
    chk("rr2 wb_busy ack", w_busy, 1'b0);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    c_en = 1'b1; c_we = 1'b1; c_addr = 24'h000010; c_sel = 4'hF;
    w_en = 1'b1; w_we = 1'b1; w_addr = 24'h000020; w_sel = 4'hF;
    #2;
    chk("rr3 addr0 core wins", addr0, 9'h004);
    chk("rr3 wb_busy", w_busy, 1'b1);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // Reset asserted in a core read's grant cycle and held one more cycle.
    c_en = 1'b1; c_we = 1'b0; c_addr = 24'h000104;
    dout0 = 64'h0; dout1 = 64'h00000000_DEADBEEF;
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("rstreq csb0", csb0, 2'b11);
    chk("rstreq csb1", csb1, 2'b11);
    chk("rstreq core_busy", c_busy, 1'b1);
    chk("rstreq core_rd", c_rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rstreq regrant csb1", csb1, 2'b10);
    chk("rstreq regrant addr1", addr1, 9'h041);
    chk("rstreq regrant busy", c_busy, 1'b1);
    @(negedge clk);
    #2;
    chk("rstreq done busy", c_busy, 1'b0);
    chk("rstreq done rd", c_rd, 32'hDEADBEEF);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
